// File: rtl/gmii_mux_sched.sv
// gmii_mux_sched: frame-aware arbiter for the GMII output mux; grants one source per frame
// and only re-arbitrates after a full inter-frame gap. Optional watchdog: GMII_MUX_SCHED_WDOG_EN.
module gmii_mux_sched #(
  parameter int C_NUM_INPUTS      = 6,
  parameter int C_IFG_BYTES       = 12,
  parameter int C_START_TIMEOUT   = 64,
  parameter int C_MAX_FRAME_BYTES = 16383
) (
  input  logic                    gtx_clk,
  input  logic                    gtx_resetn,
  input  logic [C_NUM_INPUTS-1:0] req,
  input  logic [C_NUM_INPUTS-1:0] enable_mask,
  input  logic                    prio_mode,
  input  logic                    mon_tx_en,
  output logic [C_NUM_INPUTS-1:0] grant,
  output logic [7:0]              select,
  output logic                    busy,
  output logic [31:0]             frames_cnt,
  output logic [15:0]             timeout_cnt,
  output logic                    wdog_err
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_START = 2'd1,
    ACTIVE     = 2'd2,
    IFG        = 2'd3
  } state_t;

  // One shared phase counter, wide enough for the longest limit it is compared against.
  localparam int LP_LIM = (C_MAX_FRAME_BYTES > 255) ? C_MAX_FRAME_BYTES : 255;
  localparam int LP_CW  = $clog2(LP_LIM + 1);
  localparam int LP_IW  = (C_NUM_INPUTS > 1) ? $clog2(C_NUM_INPUTS) : 1;
  localparam logic [LP_CW-1:0] LP_TMO_LAST = LP_CW'(C_START_TIMEOUT - 1);
  localparam logic [LP_CW-1:0] LP_IFG_LAST = LP_CW'(C_IFG_BYTES - 1);
`ifdef GMII_MUX_SCHED_WDOG_EN
  localparam logic [LP_CW-1:0] LP_WDOG_LAST = LP_CW'(C_MAX_FRAME_BYTES - 1);
`endif

  state_t                  r_state, w_state_nxt;
  logic [C_NUM_INPUTS-1:0] r_grant, w_grant_nxt, w_elig;
  logic [2:0]              r_last, w_last_nxt, w_win;
  logic [7:0]              r_select, w_select_nxt;
  logic [LP_CW-1:0]        r_cnt, w_cnt_nxt;
  logic [31:0]             r_frames, w_frames_nxt;
  logic [15:0]             r_tmo, w_tmo_nxt;
  logic                    r_busy, r_wdog, w_wdog_nxt;

  // Fixed mode scans 0 upward; round-robin scans last+1 upward with wrap, so last comes last.
  function automatic logic [2:0] f_pick(input logic [C_NUM_INPUTS-1:0] elig,
                                        input logic [2:0] last, input logic fixed);
    logic [2:0] win;
    logic       found;
    int         idx;
    win   = 3'd0;
    found = 1'b0;
    for (int i = 1; i <= C_NUM_INPUTS; i++) begin
      idx = fixed ? (i - 1) : ((int'(last) + i) % C_NUM_INPUTS);
      if (!found && elig[LP_IW'(idx)]) begin
        win   = 3'(idx);
        found = 1'b1;
      end
    end
    return win;
  endfunction

  // Next-state and next-output logic.
  always_comb begin
    w_elig       = req & enable_mask;
    w_win        = f_pick(w_elig, r_last, prio_mode);
    w_state_nxt  = r_state;
    w_grant_nxt  = r_grant;
    w_select_nxt = r_select;
    w_last_nxt   = r_last;
    w_cnt_nxt    = r_cnt;
    w_frames_nxt = r_frames;
    w_tmo_nxt    = r_tmo;
    w_wdog_nxt   = 1'b0;
    case (r_state)
      IDLE: begin
        w_grant_nxt = {C_NUM_INPUTS{1'b0}};
        if (|w_elig) begin
          w_state_nxt  = WAIT_START;
          w_grant_nxt  = C_NUM_INPUTS'(1'b1) << w_win;
          w_select_nxt = {5'd0, w_win};
          w_last_nxt   = w_win;
          w_cnt_nxt    = {LP_CW{1'b0}};
        end else begin
          w_state_nxt = IDLE;
        end
      end
      WAIT_START: begin
        if (mon_tx_en) begin
          w_state_nxt = ACTIVE;
          w_cnt_nxt   = {LP_CW{1'b0}};
        end else if (r_cnt == LP_TMO_LAST) begin
          w_state_nxt = IFG;
          w_grant_nxt = {C_NUM_INPUTS{1'b0}};
          w_tmo_nxt   = (r_tmo == 16'hFFFF) ? r_tmo : r_tmo + 16'd1;
          w_cnt_nxt   = {LP_CW{1'b0}};
        end else begin
          w_cnt_nxt = r_cnt + LP_CW'(1);
        end
      end
      ACTIVE: begin
        if (!mon_tx_en) begin
          w_state_nxt  = IFG;
          w_grant_nxt  = {C_NUM_INPUTS{1'b0}};
          w_frames_nxt = r_frames + 32'd1;
          w_cnt_nxt    = {LP_CW{1'b0}};
        end
`ifdef GMII_MUX_SCHED_WDOG_EN
        else if (r_cnt == LP_WDOG_LAST) begin
          w_state_nxt = IFG;
          w_grant_nxt = {C_NUM_INPUTS{1'b0}};
          w_wdog_nxt  = 1'b1;
          w_cnt_nxt   = {LP_CW{1'b0}};
        end else begin
          w_cnt_nxt = r_cnt + LP_CW'(1);
        end
`else
        else begin
          w_state_nxt = ACTIVE;
        end
`endif
      end
      IFG: begin
        if (r_cnt == LP_IFG_LAST) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = {LP_CW{1'b0}};
        end else begin
          w_cnt_nxt = r_cnt + LP_CW'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_grant_nxt = {C_NUM_INPUTS{1'b0}};
        w_cnt_nxt   = {LP_CW{1'b0}};
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge gtx_clk or negedge gtx_resetn) begin
    if (!gtx_resetn) begin
      r_state  <= IDLE;
      r_grant  <= {C_NUM_INPUTS{1'b0}};
      r_select <= 8'd0;
      r_last   <= 3'd0;
      r_cnt    <= {LP_CW{1'b0}};
      r_frames <= 32'd0;
      r_tmo    <= 16'd0;
      r_busy   <= 1'b0;
      r_wdog   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_grant  <= w_grant_nxt;
      r_select <= w_select_nxt;
      r_last   <= w_last_nxt;
      r_cnt    <= w_cnt_nxt;
      r_frames <= w_frames_nxt;
      r_tmo    <= w_tmo_nxt;
      r_busy   <= (w_state_nxt != IDLE);
      r_wdog   <= w_wdog_nxt;
    end
  end

  assign grant       = r_grant;
  assign select      = r_select;
  assign busy        = r_busy;
  assign frames_cnt  = r_frames;
  assign timeout_cnt = r_tmo;
  assign wdog_err    = r_wdog;

endmodule

// File: tb/tb_gmii_mux_sched.sv
// Bench for gmii_mux_sched: arbitration vector table, hand-written frame/timeout/reset
// sequences, and a randomized run against an event-time reference model.
module tb_gmii_mux_sched;
  localparam int N    = 6;
  localparam int IFG  = 12;
  localparam int TMO  = 64;
  localparam int MAXF = 100;

  logic         gtx_clk = 1'b0;
  logic         gtx_resetn = 1'b0;
  logic [N-1:0] req = '0;
  logic [N-1:0] enable_mask = '0;
  logic         prio_mode = 1'b0;
  logic         mon_tx_en = 1'b0;
  logic [N-1:0] grant;
  logic [7:0]   select;
  logic         busy;
  logic [31:0]  frames_cnt;
  logic [15:0]  timeout_cnt;
  logic         wdog_err;

  int checks = 0;
  int errors = 0;

  gmii_mux_sched #(
    .C_NUM_INPUTS(N), .C_IFG_BYTES(IFG), .C_START_TIMEOUT(TMO), .C_MAX_FRAME_BYTES(MAXF)
  ) dut (
    .gtx_clk(gtx_clk), .gtx_resetn(gtx_resetn), .req(req), .enable_mask(enable_mask),
    .prio_mode(prio_mode), .mon_tx_en(mon_tx_en), .grant(grant), .select(select),
    .busy(busy), .frames_cnt(frames_cnt), .timeout_cnt(timeout_cnt), .wdog_err(wdog_err)
  );

  always #4 gtx_clk = ~gtx_clk;

  typedef struct {
    logic [N-1:0] req;
    logic [N-1:0] mask;
    logic         prio;
    logic [N-1:0] exp_grant;
    logic [7:0]   exp_sel;
    logic         exp_busy;
  } vec_t;
  vec_t tbl [8];

  // Reference model: ownership plus the edge numbers at which it began/ends.
  int          m_owner, m_gedge, m_sedge, m_end, m_last;
  bit          m_started, m_wdog;
  logic [7:0]  m_sel;
  logic [31:0] m_frames;
  int          m_tmo;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge gtx_clk);
    @(negedge gtx_clk);
  endtask

  task automatic do_reset();
    @(negedge gtx_clk);
    gtx_resetn = 1'b0;
    req = '0; enable_mask = '0; prio_mode = 1'b0; mon_tx_en = 1'b0;
    @(posedge gtx_clk);
    @(negedge gtx_clk);
    gtx_resetn = 1'b1;
  endtask

  task automatic wait_grant(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (grant == '0 && n < 300);
    if (grant == '0) begin
      checks++;
      errors++;
      $display("FAIL wait_grant actual=none required=grant within %0d cycles", n);
    end
  endtask

  task automatic short_frame(input int len);
    tick(); tick();
    mon_tx_en = 1'b1;
    repeat (len) tick();
    mon_tx_en = 1'b0;
  endtask

  // Round-robin: lowest eligible index above the last winner, else the lowest overall.
  function automatic int m_pick(input logic [N-1:0] elig, input int last, input logic fixed);
    int lo, above;
    lo = -1; above = -1;
    for (int i = N - 1; i >= 0; i--) begin
      if (elig[i]) begin
        lo = i;
        if (i > last) above = i;
      end
    end
    return (fixed || above < 0) ? lo : above;
  endfunction

  task automatic model_init();
    m_owner = -1; m_end = -1; m_last = 0; m_sel = 8'd0;
    m_frames = 32'd0; m_tmo = 0; m_wdog = 1'b0; m_started = 1'b0;
    m_gedge = 0; m_sedge = 0;
  endtask

  task automatic model_step(input int e);
    logic [N-1:0] elig;
    m_wdog = 1'b0;
    if (m_owner >= 0) begin
      if (!m_started) begin
        if (mon_tx_en) begin
          m_started = 1'b1; m_sedge = e;
        end else if (e - m_gedge == TMO) begin
          m_owner = -1; m_end = e + IFG;
          if (m_tmo < 65535) m_tmo++;
        end
      end else if (!mon_tx_en) begin
        m_owner = -1; m_end = e + IFG; m_frames = m_frames + 32'd1;
      end
`ifdef GMII_MUX_SCHED_WDOG_EN
      else if (e - m_sedge == MAXF) begin
        m_owner = -1; m_end = e + IFG; m_wdog = 1'b1;
      end
`endif
    end else if (e - 1 >= m_end) begin
      elig = req & enable_mask;
      if (elig != '0) begin
        m_owner = m_pick(elig, m_last, prio_mode);
        m_gedge = e; m_started = 1'b0; m_last = m_owner; m_sel = 8'(m_owner);
      end
    end
  endtask

  initial begin
    int           n;
    int           order [7];
    int           dly, len;
    logic [N-1:0] prev_g, eg;
    logic [31:0]  r32;

    tbl[0] = '{6'b000100, 6'h3F,     1'b0, 6'b000100, 8'd2, 1'b1};
    tbl[1] = '{6'b111111, 6'h3F,     1'b0, 6'b000010, 8'd1, 1'b1};
    tbl[2] = '{6'b000001, 6'h3F,     1'b0, 6'b000001, 8'd0, 1'b1};
    tbl[3] = '{6'b101000, 6'h3F,     1'b1, 6'b001000, 8'd3, 1'b1};
    tbl[4] = '{6'b111111, 6'h3F,     1'b1, 6'b000001, 8'd0, 1'b1};
    tbl[5] = '{6'b111111, 6'h00,     1'b0, 6'b000000, 8'd0, 1'b0};
    tbl[6] = '{6'b110001, 6'b110000, 1'b0, 6'b010000, 8'd4, 1'b1};
    tbl[7] = '{6'b100001, 6'h3F,     1'b0, 6'b100000, 8'd5, 1'b1};
    order = '{1, 2, 3, 4, 5, 0, 1};

    do_reset();
    chk("reset_grant", 32'(grant), 32'd0);
    chk("reset_select", 32'(select), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_frames", frames_cnt, 32'd0);
    chk("reset_timeouts", 32'(timeout_cnt), 32'd0);
    chk("reset_wdog", 32'(wdog_err), 32'd0);

    for (int i = 0; i < 8; i++) begin
      do_reset();
      req = tbl[i].req; enable_mask = tbl[i].mask; prio_mode = tbl[i].prio;
      tick();
      chk($sformatf("vec%0d_grant", i), 32'(grant), 32'(tbl[i].exp_grant));
      chk($sformatf("vec%0d_select", i), 32'(select), 32'(tbl[i].exp_sel));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(tbl[i].exp_busy));
    end

    // Single 64-cycle frame from source 2.
    do_reset();
    req = 6'b000100; enable_mask = 6'h3F;
    tick();
    chk("frame_grant", 32'(grant), 32'h04);
    chk("frame_select", 32'(select), 32'd2);
    req = '0;
    tick(); tick();
    mon_tx_en = 1'b1;
    repeat (64) tick();
    chk("frame_grant_held", 32'(grant), 32'h04);
    mon_tx_en = 1'b0;
    tick();
    chk("frame_grant_drop", 32'(grant), 32'd0);
    chk("frame_count", frames_cnt, 32'd1);
    repeat (11) tick();
    chk("frame_ifg_busy", 32'(busy), 32'd1);
    tick();
    chk("frame_idle_busy", 32'(busy), 32'd0);
    chk("frame_select_hold", 32'(select), 32'd2);

    // Round-robin with all sources requesting.
    do_reset();
    enable_mask = 6'h3F; req = 6'h3F;
    for (int k = 0; k < 7; k++) begin
      wait_grant(n);
      chk($sformatf("rr%0d_grant", k), 32'(grant), 32'(6'b1 << order[k]));
      if (k > 0) chk($sformatf("rr%0d_gap", k), 32'(n + 2 >= IFG), 32'd1);
      short_frame(10);
    end

    // Fixed priority: source 3 always beats source 5.
    do_reset();
    enable_mask = 6'h3F; prio_mode = 1'b1; req = 6'b101000;
    for (int k = 0; k < 3; k++) begin
      wait_grant(n);
      chk($sformatf("prio%0d_grant", k), 32'(grant), 32'h08);
      short_frame(3);
    end

    // Start timeout, then the next requester after the gap.
    do_reset();
    enable_mask = 6'h3F; req = 6'b010100;
    tick();
    chk("tmo_grant", 32'(grant), 32'h04);
    req = 6'b010000;
    repeat (63) tick();
    chk("tmo_grant_held", 32'(grant), 32'h04);
    tick();
    chk("tmo_grant_drop", 32'(grant), 32'd0);
    chk("tmo_count", 32'(timeout_cnt), 32'd1);
    repeat (12) tick();
    chk("tmo_ifg_grant", 32'(grant), 32'd0);
    chk("tmo_ifg_busy", 32'(busy), 32'd0);
    tick();
    chk("tmo_next_grant", 32'(grant), 32'h10);
    chk("tmo_next_select", 32'(select), 32'd4);

    // Asynchronous reset in the middle of a frame.
    req = '0;
    tick();
    mon_tx_en = 1'b1;
    tick(); tick();
    #1 gtx_resetn = 1'b0;
    #1;
    chk("async_rst_grant", 32'(grant), 32'd0);
    chk("async_rst_select", 32'(select), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_timeouts", 32'(timeout_cnt), 32'd0);
    mon_tx_en = 1'b0;

    // Over-long frame: aborted by the watchdog when enabled, otherwise counted normally.
    do_reset();
    enable_mask = 6'h3F; req = 6'b000001;
    tick();
    chk("long_grant", 32'(grant), 32'h01);
    req = '0;
    mon_tx_en = 1'b1;
    tick();
`ifdef GMII_MUX_SCHED_WDOG_EN
    repeat (99) tick();
    chk("wdog_before", 32'(wdog_err), 32'd0);
    chk("wdog_grant_before", 32'(grant), 32'h01);
    tick();
    chk("wdog_pulse", 32'(wdog_err), 32'd1);
    chk("wdog_grant", 32'(grant), 32'd0);
    chk("wdog_frames", frames_cnt, 32'd0);
    tick();
    chk("wdog_pulse_end", 32'(wdog_err), 32'd0);
    mon_tx_en = 1'b0;
`else
    repeat (150) tick();
    chk("long_grant_held", 32'(grant), 32'h01);
    chk("long_no_wdog", 32'(wdog_err), 32'd0);
    mon_tx_en = 1'b0;
    tick();
    chk("long_frames", frames_cnt, 32'd1);
`endif

    // Randomized traffic against the reference model.
    do_reset();
    model_init();
    enable_mask = 6'h3F;
    prev_g = '0; dly = 0; len = 0;
    for (int c = 0; c < 3000; c++) begin
      if (grant != '0 && prev_g == '0) begin
        dly = ($urandom_range(0, 9) == 0) ? 90 : int'($urandom_range(1, 6));
        len = int'($urandom_range(1, 30));
      end
      prev_g = grant;
      if (dly > 0) begin
        dly--;
        mon_tx_en = 1'b0;
      end else if (len > 0) begin
        len--;
        mon_tx_en = 1'b1;
      end else begin
        mon_tx_en = (grant == '0) && ($urandom_range(0, 24) == 0);
      end
      r32 = $urandom & $urandom & $urandom;
      req = (req & ~grant) | r32[N-1:0];
      if ($urandom_range(0, 49) == 0) begin
        r32 = $urandom;
        enable_mask = ($urandom_range(0, 2) == 0) ? r32[N-1:0] : 6'h3F;
      end
      if ($urandom_range(0, 99) == 0) prio_mode = ~prio_mode;
      model_step(c);
      tick();
      eg = (m_owner >= 0) ? (6'b1 << m_owner) : 6'b0;
      chk($sformatf("rnd%0d_grant", c), 32'(grant), 32'(eg));
      chk($sformatf("rnd%0d_select", c), 32'(select), 32'(m_sel));
      chk($sformatf("rnd%0d_busy", c), 32'(busy), 32'((m_owner >= 0) || (c < m_end)));
      chk($sformatf("rnd%0d_frames", c), frames_cnt, m_frames);
      chk($sformatf("rnd%0d_timeouts", c), 32'(timeout_cnt), 32'(m_tmo));
      chk($sformatf("rnd%0d_wdog", c), 32'(wdog_err), 32'(m_wdog));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
